// File: rtl/alu_rsv_station_pkg.sv
// Shared types for the ALU reservation station: operand/entry layout, CDB
// broadcast, the ALU issue packet, and the operand wakeup helper.
package alu_rsv_station_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_TAG_W = 5;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu
    } alu_op_e;

    // Retirement-trace sideband carried untouched to the ALU.
    typedef struct packed {
        logic [31:0] insn;
        logic [15:0] order;
    } rvfi_t;

    typedef struct packed {
        logic            rdy;
        rob_tag_t        tag;
        logic [XLEN-1:0] v;
    } rs_operand_t;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [XLEN-1:0] pc;
        rob_tag_t        rob_tag;
        rvfi_t           rvfi;
        rs_operand_t     rs1;
        rs_operand_t     rs2;
    } rs_entry_t;

    typedef struct packed {
        logic            valid;
        rob_tag_t        rob_tag;
        logic [XLEN-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic            valid;
        alu_op_e         alu_op;
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            use_imm;
        rob_tag_t        rob_tag;
        rvfi_t           rvfi;
    } fu_pkt_t;

    // Capture a broadcast result into a waiting operand; ready operands are untouched.
    function automatic rs_operand_t wake_operand(rs_operand_t op, cdb_t cdb);
        rs_operand_t r;
        r = op;
        if (cdb.valid && !op.rdy && (op.tag == cdb.rob_tag)) begin
            r.rdy = 1'b1;
            r.v   = cdb.data;
        end
        return r;
    endfunction

    // Immediates already sit in rs2.v, so imm/use_imm stay zero.
    function automatic fu_pkt_t to_fu_pkt(rs_entry_t e);
        fu_pkt_t p;
        p         = '0;
        p.valid   = 1'b1;
        p.alu_op  = e.alu_op;
        p.rs1_v   = e.rs1.v;
        p.rs2_v   = e.rs2.v;
        p.pc      = e.pc;
        p.rob_tag = e.rob_tag;
        p.rvfi    = e.rvfi;
        return p;
    endfunction

endpackage

// File: rtl/alu_rsv_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
interface alu_rsv_station_if
    import alu_rsv_station_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) ();

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic           flush;
    logic           disp_valid;
    logic           disp_ready;
    rs_entry_t      disp_entry;
    cdb_t           cdb_in;
    logic           fu_ready;
    fu_pkt_t        alu_pkt_out;
    logic [IDX_W:0] occupancy;

    // Upstream side: dispatch stage, CDB and the ALU back-pressure.
    modport master (
        output flush,
        output disp_valid,
        input  disp_ready,
        output disp_entry,
        output cdb_in,
        output fu_ready,
        input  alu_pkt_out,
        input  occupancy
    );

    // Station side.
    modport slave (
        input  flush,
        input  disp_valid,
        output disp_ready,
        input  disp_entry,
        input  cdb_in,
        input  fu_ready,
        output alu_pkt_out,
        output occupancy
    );

endinterface

// File: rtl/rsv_prio_pick.sv
// Lowest-index priority picker: one-hot grant plus binary index of the first set request.
module rsv_prio_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan upward; the first request found wins and masks the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !any_o) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rsv_station.sv
// Reservation station in front of the single-cycle ALU: buffers micro-ops, wakes
// operands from the CDB, and issues the lowest-index ready entry into a registered
// packet that stalls while the ALU withholds fu_ready.
module alu_rsv_station
    import alu_rsv_station_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    alu_rsv_station_if.slave bus
);

    localparam int unsigned    IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL  = (IDX_W + 1)'(DEPTH);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    fu_pkt_t          pkt_q, pkt_d;
    logic [IDX_W:0]   occ_q, occ_d;

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] alloc_gnt, sel_gnt;
    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic             alloc_any, sel_any;
    logic             disp_ready, disp_fire, load, issue;

    // Eligibility uses registered readiness only, so a wakeup is seen one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] & entries_q[i].rs1.rdy & entries_q[i].rs2.rdy;
        end
    end

    rsv_prio_pick #(
        .N     (DEPTH),
        .IDX_W (IDX_W)
    ) u_alloc_pick (
        .req_i (~valid_q),
        .gnt_o (alloc_gnt),
        .idx_o (alloc_idx),
        .any_o (alloc_any)
    );

    rsv_prio_pick #(
        .N     (DEPTH),
        .IDX_W (IDX_W)
    ) u_sel_pick (
        .req_i (eligible),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    // Handshake decode; flush suppresses both dispatch and issue.
    always_comb begin
        disp_ready = (occ_q != FULL);
        disp_fire  = bus.disp_valid && disp_ready && alloc_any && !bus.flush;
        load       = !pkt_q.valid || bus.fu_ready;
        issue      = load && sel_any && !bus.flush;
    end

    // Entry array next state: wakeup, free on issue, allocate on dispatch, squash on flush.
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].rs1 = wake_operand(entries_q[i].rs1, bus.cdb_in);
            entries_d[i].rs2 = wake_operand(entries_q[i].rs2, bus.cdb_in);
        end
        if (issue) begin
            valid_d = valid_d & ~sel_gnt;
        end
        if (disp_fire) begin
            // Allocation targets a free slot, so it never collides with the issuing one.
            entries_d[alloc_idx]     = bus.disp_entry;
            entries_d[alloc_idx].rs1 = wake_operand(bus.disp_entry.rs1, bus.cdb_in);
            entries_d[alloc_idx].rs2 = wake_operand(bus.disp_entry.rs2, bus.cdb_in);
            valid_d                  = valid_d | alloc_gnt;
        end
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    // Output register: load the selected entry (or a bubble) unless stalled.
    always_comb begin
        pkt_d = pkt_q;
        if (bus.flush) begin
            pkt_d = '0;
        end else if (load) begin
            pkt_d = sel_any ? to_fu_pkt(entries_q[sel_idx]) : '0;
        end
    end

    // Occupancy tracks accepted dispatches minus issues.
    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + {{IDX_W{1'b0}}, disp_fire} - {{IDX_W{1'b0}}, issue};
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pkt_q   <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            occ_q   <= occ_d;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign bus.disp_ready  = disp_ready;
    assign bus.alu_pkt_out = pkt_q;
    assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: expected ALU packets are queued at
// dispatch and compared whenever the ALU accepts a packet (valid && fu_ready).
module tb_alu_rsv_station;
    import alu_rsv_station_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    alu_rsv_station_if #(.DEPTH(DEPTH)) bus ();

    alu_rsv_station #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_errors = 0;
    fu_pkt_t sb_q [$];
    fu_pkt_t mon_exp;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rs_entry_t mk_entry(input rob_tag_t tag, input alu_op_e op,
                                           input logic r1_rdy, input rob_tag_t r1_tag,
                                           input logic [31:0] r1_v,
                                           input logic r2_rdy, input rob_tag_t r2_tag,
                                           input logic [31:0] r2_v);
        rs_entry_t e;
        e.alu_op     = op;
        e.pc         = 32'h1000 + (32'(tag) << 2);
        e.rob_tag    = tag;
        e.rvfi.insn  = 32'h0000_0013 ^ 32'(tag);
        e.rvfi.order = 16'(tag) + 16'd100;
        e.rs1.rdy    = r1_rdy;
        e.rs1.tag    = r1_tag;
        e.rs1.v      = r1_v;
        e.rs2.rdy    = r2_rdy;
        e.rs2.tag    = r2_tag;
        e.rs2.v      = r2_v;
        return e;
    endfunction

    // Packet the ALU should see: copied fields, operand values, everything else zero.
    function automatic fu_pkt_t exp_pkt(input rs_entry_t e, input logic [31:0] v1,
                                        input logic [31:0] v2);
        fu_pkt_t p;
        p         = '0;
        p.valid   = 1'b1;
        p.alu_op  = e.alu_op;
        p.rs1_v   = v1;
        p.rs2_v   = v2;
        p.pc      = e.pc;
        p.rob_tag = e.rob_tag;
        p.rvfi    = e.rvfi;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input rs_entry_t e);
        bus.disp_valid = 1'b1;
        bus.disp_entry = e;
    endtask

    task automatic drive_cdb(input rob_tag_t tag, input logic [31:0] data);
        bus.cdb_in.valid   = 1'b1;
        bus.cdb_in.rob_tag = tag;
        bus.cdb_in.data    = data;
    endtask

    // Scoreboard: every packet the ALU takes must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.alu_pkt_out.valid && bus.fu_ready) begin
            check("sb_nonempty", 256'(sb_q.size() != 0), 256'(1));
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check("issue_pkt", 256'(bus.alu_pkt_out), 256'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rs_entry_t e;
        rs_entry_t op9;

        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_entry = '0;
        bus.cdb_in     = '0;
        bus.fu_ready   = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_occ", 256'(bus.occupancy), 256'(0));
        check("rst_valid", 256'(bus.alu_pkt_out.valid), 256'(0));
        check("rst_disp_ready", 256'(bus.disp_ready), 256'(1));
        #9 rst_n = 1'b1;
        tick();

        // All-ready op: packet appears two edges after dispatch
        bus.fu_ready = 1'b1;
        e = mk_entry(5'd3, AluAdd, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        sb_q.push_back(exp_pkt(e, 32'd5, 32'd7));
        drive_disp(e);
        tick();
        bus.disp_valid = 1'b0;
        check("t1_occ_after_disp", 256'(bus.occupancy), 256'(1));
        check("t1_not_yet", 256'(bus.alu_pkt_out.valid), 256'(0));
        tick();
        check("t1_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        check("t1_rs1_v", 256'(bus.alu_pkt_out.rs1_v), 256'(5));
        check("t1_rs2_v", 256'(bus.alu_pkt_out.rs2_v), 256'(7));
        check("t1_rob_tag", 256'(bus.alu_pkt_out.rob_tag), 256'(3));
        check("t1_occ_zero", 256'(bus.occupancy), 256'(0));
        tick();
        check("t1_drained", 256'(bus.alu_pkt_out.valid), 256'(0));

        // rs1 waits on tag 9; CDB three cycles later; issue one cycle after broadcast
        e = mk_entry(5'd10, AluSub, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'h22);
        sb_q.push_back(exp_pkt(e, 32'h1234, 32'h22));
        drive_disp(e);
        tick();
        bus.disp_valid = 1'b0;
        tick();
        tick();
        check("t2_waiting", 256'(bus.alu_pkt_out.valid), 256'(0));
        drive_cdb(5'd9, 32'h1234);
        tick();
        bus.cdb_in = '0;
        check("t2_not_same_cycle", 256'(bus.alu_pkt_out.valid), 256'(0));
        tick();
        check("t2_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        check("t2_rs1_v", 256'(bus.alu_pkt_out.rs1_v), 256'h1234);
        tick();

        // Dispatch bypass: rs2 tag 4 broadcast in the dispatch cycle
        e = mk_entry(5'd11, AluXor, 1'b1, 5'd0, 32'h3, 1'b0, 5'd4, 32'd0);
        sb_q.push_back(exp_pkt(e, 32'h3, 32'hAA));
        drive_disp(e);
        drive_cdb(5'd4, 32'hAA);
        tick();
        bus.disp_valid = 1'b0;
        bus.cdb_in     = '0;
        check("t3_not_yet", 256'(bus.alu_pkt_out.valid), 256'(0));
        tick();
        check("t3_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        check("t3_rs2_v", 256'(bus.alu_pkt_out.rs2_v), 256'hAA);
        tick();

        // Stall: first op parks in the output register, then fill all 8 entries
        bus.fu_ready = 1'b0;
        e = mk_entry(5'd16, AluAnd, 1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
        sb_q.push_back(exp_pkt(e, 32'd100, 32'd200));
        drive_disp(e);
        tick();
        bus.disp_valid = 1'b0;
        tick();
        check("t4_parked", 256'(bus.alu_pkt_out.rob_tag), 256'(16));
        for (int i = 1; i <= 8; i++) begin
            e = mk_entry(rob_tag_t'(16 + i), AluOr, 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(3 * i));
            sb_q.push_back(exp_pkt(e, 32'(i), 32'(3 * i)));
            check("t4_disp_ready", 256'(bus.disp_ready), 256'(1));
            drive_disp(e);
            tick();
        end
        bus.disp_valid = 1'b0;
        check("t4_full_occ", 256'(bus.occupancy), 256'(8));
        check("t4_full_ready", 256'(bus.disp_ready), 256'(0));
        tick();
        tick();
        check("t4_hold_tag", 256'(bus.alu_pkt_out.rob_tag), 256'(16));
        check("t4_hold_rs1", 256'(bus.alu_pkt_out.rs1_v), 256'(100));
        check("t4_hold_occ", 256'(bus.occupancy), 256'(8));

        // Full station: issue and dispatch in the same cycle -> refused, then accepted
        op9 = mk_entry(5'd25, AluSlt, 1'b0, 5'd30, 32'd0, 1'b1, 5'd0, 32'd9);
        bus.fu_ready = 1'b1;
        drive_disp(op9);
        check("t5_full_refuse", 256'(bus.disp_ready), 256'(0));
        tick();
        check("t5_refused_occ", 256'(bus.occupancy), 256'(7));
        check("t5_ready_again", 256'(bus.disp_ready), 256'(1));
        check("t5_first_issue", 256'(bus.alu_pkt_out.rob_tag), 256'(17));
        tick();
        sb_q.push_back(exp_pkt(op9, 32'h55, 32'd9));
        bus.disp_valid = 1'b0;
        check("t5_balance_occ", 256'(bus.occupancy), 256'(7));
        check("t5_second_issue", 256'(bus.alu_pkt_out.rob_tag), 256'(18));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_stream_tag", 256'(bus.alu_pkt_out.rob_tag), 256'(19 + i));
            check("t5_stream_occ", 256'(bus.occupancy), 256'(6 - i));
        end
        tick();
        check("t5_blocked", 256'(bus.alu_pkt_out.valid), 256'(0));
        check("t5_blocked_occ", 256'(bus.occupancy), 256'(1));
        drive_cdb(5'd30, 32'h55);
        tick();
        bus.cdb_in = '0;
        check("t5_wake_wait", 256'(bus.alu_pkt_out.valid), 256'(0));
        tick();
        check("t5_late_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        check("t5_late_rs1", 256'(bus.alu_pkt_out.rs1_v), 256'h55);
        check("t5_empty", 256'(bus.occupancy), 256'(0));
        tick();

        // Flush with 5 entries and a stalled output; concurrent dispatch is dropped
        bus.fu_ready = 1'b0;
        drive_disp(mk_entry(5'd1, AluAdd, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1));
        tick();
        bus.disp_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_disp(mk_entry(rob_tag_t'(2 + i), AluAdd, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0));
            tick();
        end
        check("t6_pre_occ", 256'(bus.occupancy), 256'(5));
        check("t6_pre_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        drive_disp(mk_entry(5'd7, AluAdd, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0));
        bus.flush = 1'b1;
        tick();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        check("t6_flush_occ", 256'(bus.occupancy), 256'(0));
        check("t6_flush_valid", 256'(bus.alu_pkt_out.valid), 256'(0));
        check("t6_flush_ready", 256'(bus.disp_ready), 256'(1));
        bus.fu_ready = 1'b1;
        tick();
        tick();
        check("t6_quiet", 256'(bus.alu_pkt_out.valid), 256'(0));

        // Asynchronous reset mid-stream, checked before the next clock edge
        bus.fu_ready = 1'b0;
        drive_disp(mk_entry(5'd8, AluAdd, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0));
        tick();
        bus.disp_valid = 1'b0;
        tick();
        drive_disp(mk_entry(5'd12, AluAdd, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0));
        tick();
        drive_disp(mk_entry(5'd13, AluAdd, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0));
        tick();
        bus.disp_valid = 1'b0;
        check("t7_pre_occ", 256'(bus.occupancy), 256'(2));
        check("t7_pre_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_occ", 256'(bus.occupancy), 256'(0));
        check("t7_async_valid", 256'(bus.alu_pkt_out.valid), 256'(0));
        check("t7_async_ready", 256'(bus.disp_ready), 256'(1));
        #3 rst_n = 1'b1;
        tick();

        // Station still works after the mid-stream reset
        bus.fu_ready = 1'b1;
        e = mk_entry(5'd14, AluSltu, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        sb_q.push_back(exp_pkt(e, 32'hDEAD, 32'hBEEF));
        drive_disp(e);
        tick();
        bus.disp_valid = 1'b0;
        tick();
        check("t8_valid", 256'(bus.alu_pkt_out.valid), 256'(1));
        tick();
        tick();
        check("sb_drained", 256'(sb_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_rsv_station.md
Name: alu_rsv_station

Overview:
- Reservation station directly upstream of the single-cycle ALU functional unit.
- Buffers dispatched ALU micro-ops and wakes operands by snooping the CDB.
- Selects one fully-ready entry per cycle and drives a registered fu_pkt_t into the ALU.
- The ALU's cdb_t result returns on the CDB and wakes dependants in this station.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..16.
- IDX_W, $clog2(DEPTH), entry index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries and the output register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_entry  in  rs_entry_t  op (alu_op, pc, rob_tag, rvfi, rs1/rs2 {rdy, tag, v}).
- cdb_in  in  cdb_t  broadcast bus (valid, rob_tag, data).
- fu_ready  in  1  ALU/CDB slot can take a packet this cycle.
- alu_pkt_out  out  fu_pkt_t  registered issue packet to the ALU.
- occupancy  out  IDX_W+1  number of valid entries.

Behaviour:
- Reset (rst_n low, async): all entry valid bits = 0; alu_pkt_out = '0 (so .valid = 0); occupancy = 0; disp_ready = 1 after reset.
- Dispatch:
  - Accepted when disp_valid && disp_ready && !flush; written into the lowest-index free entry.
  - disp_ready = (occupancy != DEPTH), computed from registered state only; a same-cycle issue does not free a slot for same-cycle dispatch.
  - Immediates arrive as rs2.v with rs2.rdy = 1.
- Wakeup:
  - Each cycle cdb_in.valid: every valid entry with rsX.rdy = 0 and rsX.tag == cdb_in.rob_tag sets rsX.rdy = 1 and rsX.v = cdb_in.data.
  - Dispatch bypass: if the dispatched operand is not ready and its tag matches the same-cycle CDB, the entry is written ready with the CDB data.
  - Both operands may wake on the same broadcast.
- Ready/select:
  - An entry is eligible when valid && rs1.rdy && rs2.rdy, using registered state.
  - An entry woken at edge N is eligible in cycle N+1, never the same cycle.
  - Select the lowest-index eligible entry.
- Issue/output register:
  - If alu_pkt_out.valid == 0 or fu_ready == 1, the register loads: the selected entry (valid = 1) and frees that entry at the same edge, or valid = 0 if none is eligible.
  - If alu_pkt_out.valid && !fu_ready, the register holds every field stable, nothing issues, and entries stay.
  - alu_pkt_out fields: rs1_v, rs2_v, alu_op, pc, rob_tag, rvfi copied from the entry; remaining fields are '0.
  - Latency: dispatch of an all-ready op at edge N, select in cycle N+1, alu_pkt_out.valid after edge N+1 (2 edges from dispatch).
- Occupancy: next = occupancy + dispatch accepted − issue; simultaneous dispatch and issue leaves it unchanged.
- Flush: at the next edge all entries are invalid, alu_pkt_out.valid = 0 and occupancy = 0; any dispatch that cycle is dropped. Flush dominates dispatch, issue and wakeup.
- Reset mid-operation: asynchronously clears state regardless of fu_ready.
- No tag check on rob_tag uniqueness; upstream guarantees unique in-flight tags.

Decomposition:
- types package:
  - rs_entry_t (operand sub-struct {rdy, tag, v} ×2, alu_op, pc, rob_tag, rvfi).
  - Reuses the existing fu_pkt_t, cdb_t, alu op enum and ROB tag width.
- One sub-module: rsv_prio_pick, a parameterised lowest-index one-hot/index picker used twice (free-slot allocation and ready-entry select).

Test Plan:
- Reset then dispatch add_op, rs1 = 5 ready, rs2 = 7 ready, rob_tag 3, fu_ready = 1 -> alu_pkt_out.valid after 2 edges with rs1_v = 5, rs2_v = 7, rob_tag = 3; occupancy returns to 0.
- Dispatch op with rs1 tag 9 not ready; 3 cycles later cdb_in {valid, rob_tag 9, data 0x1234} -> issue exactly one cycle after the broadcast with rs1_v = 0x1234.
- Dispatch with rs2 tag 4 not ready while same-cycle cdb_in {rob_tag 4, data 0xAA} -> entry ready immediately, issues 2 edges later with rs2_v = 0xAA.
- Fill 8 all-ready entries with fu_ready = 0 -> disp_ready = 0, occupancy = 8, alu_pkt_out holds entry 0 unchanged. Raise fu_ready -> entries issue in index order 0..7, one per cycle.
- Full station plus same-cycle issue and disp_valid -> dispatch refused this cycle, accepted next cycle; occupancy never exceeds 8.
- Flush with 5 entries and a stalled output -> next edge occupancy = 0, alu_pkt_out.valid = 0. Then rst_n asserted mid-stream clears state asynchronously, before the next clock edge.
